imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe_pkg.sv | 20 ++
 rtl/imm_decode.sv | 38 +++
 rtl/imm_gen_pipe.sv | 103 ++++++++++
 tb/tb_imm_gen_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// rtl/imm_gen_pipe_pkg.sv - shared constants for the immediate generator pipeline
package imm_gen_pipe_pkg;

   // Default width of the extended immediate (32 or 64)
   localparam int XLEN_DEFAULT = 32;

   // immediate_source encodings
   localparam logic [2:0] SEL_I = 3'b000;
   localparam logic [2:0] SEL_S = 3'b001;
   localparam logic [2:0] SEL_B = 3'b010;
   localparam logic [2:0] SEL_U = 3'b011;
   localparam logic [2:0] SEL_J = 3'b100;
   localparam logic [2:0] SEL_Z = 3'b101;

   // True for the two reserved selects (110, 111)
   function automatic logic sel_is_illegal(input logic [2:0] sel);
      return (sel == 3'b110) || (sel == 3'b111);
   endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate extraction and extension
module imm_decode
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:0]     instruction,
   input  logic [2:0]      select,
   output logic [XLEN-1:0] immediate,
   output logic            illegal
);

   logic        s;
   logic [31:0] raw;
   logic        unused_opcode;

   assign s = instruction[31];
   // Opcode field carries no immediate bits
   assign unused_opcode = ^instruction[6:0];

   // Build a 32-bit immediate; Z leaves bit 31 clear so the shared sign extension becomes zero extension
   always_comb begin
      raw     = '0;
      illegal = 1'b0;
      case (select)
         SEL_I:   raw = {{20{s}}, instruction[31:20]};
         SEL_S:   raw = {{20{s}}, instruction[31:25], instruction[11:7]};
         SEL_B:   raw = {{19{s}}, s, instruction[7], instruction[30:25], instruction[11:8], 1'b0};
         SEL_U:   raw = {instruction[31:12], 12'b0};
         SEL_J:   raw = {{11{s}}, s, instruction[19:12], instruction[20], instruction[30:21], 1'b0};
         SEL_Z:   raw = {27'b0, instruction[19:15]};
         default: illegal = sel_is_illegal(select);
      endcase
   end

   assign immediate = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate decode followed by a two-entry elastic buffer
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          full_instruction,
   input  logic [2:0]           immediate_source,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      immediate_extended,
   output logic                 illegal,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic [XLEN-1:0] dec_imm;
   logic            dec_ill;

   logic            rdy_q;
   logic            skid_v, skid_v_n, out_v_n;
   logic [XLEN-1:0] skid_imm, skid_imm_n, out_imm_n;
   logic            skid_ill, skid_ill_n, out_ill_n;
   logic            accept, out_free;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instruction (full_instruction),
      .select      (immediate_source),
      .immediate   (dec_imm),
      .illegal     (dec_ill)
   );

   // Flush gates the port directly so a beat offered during flush is never handshaken
   assign in_ready = rdy_q & ~flush;
   assign accept   = in_valid & in_ready;
   assign out_free = ~out_valid | out_ready;

   // Next-state of output and skid entries: flush wins, skid drains first, otherwise bypass to output
   always_comb begin
      out_v_n    = out_valid;
      out_imm_n  = immediate_extended;
      out_ill_n  = illegal;
      skid_v_n   = skid_v;
      skid_imm_n = skid_imm;
      skid_ill_n = skid_ill;
      if (flush) begin
         out_v_n  = 1'b0;
         skid_v_n = 1'b0;
      end else if (out_free) begin
         if (skid_v) begin
            out_v_n   = 1'b1;
            out_imm_n = skid_imm;
            out_ill_n = skid_ill;
            skid_v_n  = accept;
            if (accept) begin
               skid_imm_n = dec_imm;
               skid_ill_n = dec_ill;
            end
         end else if (accept) begin
            out_v_n   = 1'b1;
            out_imm_n = dec_imm;
            out_ill_n = dec_ill;
         end else begin
            out_v_n = 1'b0;
         end
      end else if (accept) begin
         skid_v_n   = 1'b1;
         skid_imm_n = dec_imm;
         skid_ill_n = dec_ill;
      end
   end

   // Buffer state, registered ready and saturating illegal counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid          <= 1'b0;
         immediate_extended <= '0;
         illegal            <= 1'b0;
         skid_v             <= 1'b0;
         skid_imm           <= '0;
         skid_ill           <= 1'b0;
         rdy_q              <= 1'b0;
         err_count          <= '0;
      end else begin
         out_valid          <= out_v_n;
         immediate_extended <= out_imm_n;
         illegal            <= out_ill_n;
         skid_v             <= skid_v_n;
         skid_imm           <= skid_imm_n;
         skid_ill           <= skid_ill_n;
         rdy_q              <= ~skid_v_n;
         if (accept && dec_ill && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] inst = '0;
   logic [2:0]  sel = '0;

   logic        in_ready, out_valid, ill;
   logic [31:0] imm32;
   logic [7:0]  err;
   logic        in_ready64, out_valid64, ill64;
   logic [63:0] imm64;
   logic [7:0]  err64;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] q_imm[$];
   logic        q_ill[$];
   int          ecnt = 0;
   int          acc_cnt = 0;
   bit          chk_rdy = 0;

   imm_gen_pipe #(.XLEN(32), .ERR_CNT_W(8)) dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .full_instruction(inst), .immediate_source(sel), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .immediate_extended(imm32),
      .illegal(ill), .err_count(err)
   );

   imm_gen_pipe #(.XLEN(64), .ERR_CNT_W(8)) dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
      .full_instruction(inst), .immediate_source(sel), .flush(flush),
      .out_valid(out_valid64), .out_ready(out_ready), .immediate_extended(imm64),
      .illegal(ill64), .err_count(err64)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference immediate from field arithmetic on a sign-extended word
   function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] f);
      longint s;
      longint u;
      s = $signed(w);
      u = {32'b0, w};
      case (f)
         3'd0: return s >>> 20;
         3'd1: return ((s >>> 25) <<< 5) | ((u >> 7) & 31);
         3'd2: return ((s >>> 31) <<< 12) | (((u >> 7) & 1) << 11)
                      | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
         3'd3: return (s >>> 12) <<< 12;
         3'd4: return ((s >>> 31) <<< 20) | (((u >> 12) & 255) << 12)
                      | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
         3'd5: return (u >> 15) & 31;
         default: return 64'd0;
      endcase
   endfunction

   // Compare against the queue model, then advance the model across the coming edge
   always @(negedge clk) begin
      if (!reset) begin
         check("out_valid", out_valid, q_imm.size() != 0);
         check("out_valid64", out_valid64, q_imm.size() != 0);
         if (q_imm.size() != 0) begin
            check("imm32", imm32, {32'b0, q_imm[0][31:0]});
            check("imm64", imm64, q_imm[0]);
            check("illegal", ill, q_ill[0]);
            check("illegal64", ill64, q_ill[0]);
         end
         check("err_count", err, ecnt);
         if (chk_rdy) check("in_ready", in_ready, (q_imm.size() < 2) && !flush);
         if (flush) begin
            q_imm.delete();
            q_ill.delete();
         end else begin
            if (out_valid && out_ready && q_imm.size() != 0) begin
               void'(q_imm.pop_front());
               void'(q_ill.pop_front());
            end
            if (in_valid && in_ready) begin
               q_imm.push_back(ref_imm(inst, sel));
               q_ill.push_back(sel >= 3'd6);
               if (sel >= 3'd6 && ecnt < 255) ecnt++;
               acc_cnt++;
            end
         end
      end
   end

   task automatic send(input logic [31:0] w, input logic [2:0] f, input logic [31:0] exp32,
                       input string name);
      @(posedge clk); #1;
      in_valid = 1'b1; inst = w; sel = f;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check(name, imm32, {32'b0, exp32});
   endtask

   initial begin
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_imm", imm32, 0);
      check("rst_illegal", ill, 0);
      check("rst_err", err, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("ready_before_edge", in_ready, 0);
      @(negedge clk);
      check("ready_after_edge", in_ready, 1);
      chk_rdy = 1;
      @(posedge clk); #1 out_ready = 1'b1;

      send(32'hFFF00093, 3'd0, 32'hFFFFFFFF, "lit_I");
      send(32'hFE20AE23, 3'd1, 32'hFFFFFFFC, "lit_S");
      send(32'hFE000CE3, 3'd2, 32'hFFFFFFF8, "lit_B");
      send(32'h123450B7, 3'd3, 32'h12345000, "lit_U");
      send(32'h800000EF, 3'd4, 32'hFFF00000, "lit_J");
      check("lit_J64", imm64, 64'hFFFFFFFFFFF00000);
      send(32'h0001D073, 3'd5, 32'h00000003, "lit_Z");

      // Random traffic with random backpressure and occasional flush
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         inst      = $urandom;
         sel       = 3'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);

      // Backpressure: three offered beats, only two fit
      #1 out_ready = 1'b0; acc_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; inst = 32'h00100093 + (i << 20); sel = 3'd0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp_accepted", acc_cnt, 2);
      @(negedge clk);
      check("bp_ready_low", in_ready, 0);
      @(posedge clk); #1 out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("bp_drained", out_valid, 0);

      // 300 illegal beats back to back
      @(posedge clk); #1;
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'b1; inst = $urandom; sel = 3'd7;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("err_saturated", err, 255);

      // Flush with both entries held
      @(posedge clk); #1 out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; inst = 32'hFFF00093; sel = 3'd7;
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", out_valid, 0);
      check("flush_err", err, 255);

      // A beat offered during flush is not taken
      @(posedge clk); #1;
      in_valid = 1'b1; flush = 1'b1; sel = 3'd0;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_blocks_accept", out_valid, 0);

      // Reset mid-stream with both entries full
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; inst = 32'h123450B7; sel = 3'd3;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #2 reset = 1'b1;
      chk_rdy = 0;
      q_imm.delete();
      q_ill.delete();
      ecnt = 0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_in_ready", in_ready, 0);
      check("async_rst_err", err, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rerst_ready_before_edge", in_ready, 0);
      @(negedge clk);
      check("rerst_ready_after_edge", in_ready, 1);
      chk_rdy = 1;
      send(32'h800000EF, 3'd4, 32'hFFF00000, "post_reset_J");

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
